// File: rtl/kb_repeat_fifo_pkg.sv
// kb_repeat_fifo_pkg: shared state encodings, entry layout and timing defaults
package kb_repeat_fifo_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_DELAY, ST_REPEAT} state_t;
    localparam int ENTRY_W = 13;
    localparam int KB_ASCII_LSB = 0;
    localparam int KB_FLAGS_LSB = 8;
    localparam int MS500 = 25000000;
    localparam int MS250 = 12500000;
endpackage

// File: rtl/kb_repeat_fifo_event_fifo.sv
// kb_event_fifo: show-ahead event storage; empty reads as zero, full push needs a pop
module kb_event_fifo import kb_repeat_fifo_pkg::*; #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [ENTRY_W-1:0]       din,
    input  logic                     pop,
    output logic [ENTRY_W-1:0]       dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic do_push, do_pop;
    assign empty = count_q == '0;
    assign full  = count_q == CW'(DEPTH);
    assign count = count_q;
    assign dout  = empty ? '0 : mem[rd_ptr_q];
    // pointer and occupancy update; a pop frees the slot a full push needs
    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = (do_push && !do_pop) ? count_q + CW'(1) :
                   (do_pop && !do_push) ? count_q - CW'(1) : count_q;
    end
    // state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
    // entry RAM, no reset needed
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= din;
    end
endmodule

// File: rtl/kb_repeat_fifo.sv
// kb_repeat_fifo: key press / auto-repeat event generator feeding a show-ahead FIFO
// Auto-repeat timing is built only when KB_REPEAT_EN is defined; otherwise a held key pushes once.
module kb_repeat_fifo import kb_repeat_fifo_pkg::*; #(
    parameter int DEPTH  = 16,
    parameter int DELAY  = MS500,
    parameter int PERIOD = MS250
) (
    input  logic                   CLOCK_50,
    input  logic                   rst,
    input  logic [7:0]             ascii,
    input  logic [4:0]             kb_flags,
    input  logic                   rd_en,
    input  logic                   ovf_clr,
    output logic [31:0]            kb_data,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow
);
    state_t state_q, state_d;
    logic [7:0] cur_key_q, cur_key_d;
    logic ovf_q, ovf_d;
    logic push, full;
    logic [ENTRY_W-1:0] head;
`ifdef KB_REPEAT_EN
    logic [31:0] timer_q, timer_d;
`else
    localparam int unused_timing = DELAY + PERIOD;
`endif
    // press FSM: new key or key change always wins over a timer expiry
    always_comb begin
        state_d   = state_q;
        cur_key_d = cur_key_q;
        push      = 1'b0;
`ifdef KB_REPEAT_EN
        timer_d   = timer_q + 32'd1;
`endif
        case (state_q)
            ST_IDLE:
                if (ascii != 8'd0) begin
                    push      = 1'b1;
                    cur_key_d = ascii;
                    state_d   = ST_DELAY;
                end
            default:
                if (ascii == 8'd0) state_d = ST_IDLE;
                else if (ascii != cur_key_q) begin
                    push      = 1'b1;
                    cur_key_d = ascii;
                    state_d   = ST_DELAY;
                end
`ifdef KB_REPEAT_EN
                else if (state_q == ST_DELAY && timer_q == 32'(DELAY - 1)) begin
                    push    = 1'b1;
                    state_d = ST_REPEAT;
                end else if (state_q == ST_REPEAT && timer_q == 32'(PERIOD - 1)) push = 1'b1;
`endif
        endcase
`ifdef KB_REPEAT_EN
        if (push || state_d == ST_IDLE) timer_d = '0;
`endif
        ovf_d = (push && full && !rd_en) ? 1'b1 : ovf_clr ? 1'b0 : ovf_q;
    end
    // FSM, timer and sticky overflow registers
    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cur_key_q <= '0;
            ovf_q     <= 1'b0;
`ifdef KB_REPEAT_EN
            timer_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cur_key_q <= cur_key_d;
            ovf_q     <= ovf_d;
`ifdef KB_REPEAT_EN
            timer_q   <= timer_d;
`endif
        end
    end
    kb_event_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (CLOCK_50),
        .rst   (rst),
        .push  (push && !rst),
        .din   ({kb_flags, ascii}),
        .pop   (rd_en && !rst),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );
    assign kb_data  = {19'd0, head};
    assign overflow = ovf_q;
endmodule

// File: tb/tb_kb_repeat_fifo.sv
// tb_kb_repeat_fifo: directed and random stimulus against a press-age reference model
module tb_kb_repeat_fifo;
    localparam int DEPTH = 4;
    localparam int DLY   = 4;
    localparam int PER   = 2;
`ifdef KB_REPEAT_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif
    logic CLOCK_50 = 1'b0;
    logic rst = 1'b1;
    logic [7:0] ascii = '0;
    logic [4:0] kb_flags = '0;
    logic rd_en = 1'b0;
    logic ovf_clr = 1'b0;
    logic [31:0] kb_data;
    logic empty;
    logic [2:0] count;
    logic overflow;
    int n_cmp = 0;
    int n_fail = 0;
    logic [12:0] mq[$];
    logic [7:0] m_key = '0;
    int m_age = 0;
    logic m_ovf = 1'b0;

    always #5 CLOCK_50 = ~CLOCK_50;

    kb_repeat_fifo #(.DEPTH(DEPTH), .DELAY(DLY), .PERIOD(PER)) dut (
        .CLOCK_50 (CLOCK_50),
        .rst      (rst),
        .ascii    (ascii),
        .kb_flags (kb_flags),
        .rd_en    (rd_en),
        .ovf_clr  (ovf_clr),
        .kb_data  (kb_data),
        .empty    (empty),
        .count    (count),
        .overflow (overflow)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // One clock: a key held for age cycles repeats at age DLY, DLY+PER, DLY+2*PER, ...
    task automatic cyc(input logic [7:0] a, input logic rd = 1'b0, input logic clr = 1'b0,
                       input logic r = 1'b0, input logic [4:0] f = 5'd0);
        logic p, pop_ok, full;
        ascii = a; kb_flags = f; rd_en = rd; ovf_clr = clr; rst = r;
        if (r) begin
            mq.delete();
            m_key = '0;
            m_ovf = 1'b0;
        end else begin
            p = 1'b0;
            if (a == 8'd0) m_key = '0;
            else if (a != m_key) begin
                m_key = a;
                m_age = 0;
                p = 1'b1;
            end else begin
                m_age++;
                p = REP && (m_age == DLY || (m_age > DLY && (m_age - DLY) % PER == 0));
            end
            pop_ok = rd && mq.size() > 0;
            full = mq.size() == DEPTH;
            if (pop_ok) void'(mq.pop_front());
            if (p && (!full || pop_ok)) mq.push_back({f, a});
            m_ovf = (p && full && !pop_ok) ? 1'b1 : clr ? 1'b0 : m_ovf;
        end
        @(posedge CLOCK_50);
        #1;
        chk("kb_data", kb_data, mq.size() > 0 ? {19'd0, mq[0]} : 32'd0);
        chk("empty", {31'd0, empty}, {31'd0, mq.size() == 0});
        chk("count", {29'd0, count}, 32'(mq.size()));
        chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
    endtask

    task automatic drain();
        repeat (DEPTH + 1) cyc(8'd0, 1'b1);
    endtask

    initial begin
        cyc(8'd0, 1'b0, 1'b0, 1'b1);
        cyc(8'd0, 1'b0, 1'b0, 1'b1);
        chk("reset_data", kb_data, 32'd0);
        chk("reset_empty", {31'd0, empty}, 32'd1);
        // single press
        repeat (3) cyc(8'h41);
        cyc(8'h00);
        chk("single_data", kb_data, 32'h00000041);
        chk("single_count", {29'd0, count}, 32'd1);
        drain();
        // auto-repeat: pushes at press, +4, +6
        repeat (8) cyc(8'h61);
        cyc(8'h00);
        chk("repeat_count", {29'd0, count}, REP ? 32'd3 : 32'd1);
        drain();
        // key change restarts the delay
        repeat (2) cyc(8'h61);
        repeat (6) cyc(8'h62);
        cyc(8'h00);
        chk("change_head", kb_data, 32'h00000061);
        chk("change_count", {29'd0, count}, REP ? 32'd3 : 32'd2);
        drain();
        // overflow with five distinct presses
        for (int i = 0; i < 5; i++) cyc(8'h41 + 8'(i));
        cyc(8'h00);
        chk("ovf_count", {29'd0, count}, 32'd4);
        chk("ovf_flag", {31'd0, overflow}, 32'd1);
        cyc(8'h00, 1'b0, 1'b1);
        chk("ovf_clr", {31'd0, overflow}, 32'd0);
        // full boundary: press with a pop in the same cycle
        cyc(8'h50, 1'b1);
        chk("full_pp_count", {29'd0, count}, 32'd4);
        chk("full_pp_ovf", {31'd0, overflow}, 32'd0);
        chk("full_pp_head", kb_data, 32'h00000042);
        cyc(8'h00);
        drain();
        // reset during repeat with the key still held
        repeat (8) cyc(8'h70);
        cyc(8'h70, 1'b0, 1'b0, 1'b1);
        chk("rst_rep_empty", {31'd0, empty}, 32'd1);
        cyc(8'h70);
        chk("rst_rep_push", {29'd0, count}, 32'd1);
        cyc(8'h00);
        drain();
        // randomized traffic
        for (int s = 0; s < 80; s++) begin
            logic [7:0] k;
            int len;
            k = ($urandom % 4 == 0) ? 8'h00 : 8'h41 + 8'($urandom % 3);
            len = 1 + int'($urandom % 12);
            for (int c = 0; c < len; c++)
                cyc(k, $urandom % 4 == 0, $urandom % 8 == 0, $urandom % 100 == 0, 5'($urandom));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
